// File: rtl/seq_signed_divider.sv
// Multi-cycle restoring signed divider: one quotient bit per clock over operand magnitudes,
// sign-corrected on entry to DONE. Optional zero-divisor fast path: DIV_ZERO_DETECT_EN.
module seq_signed_divider #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             start,
   input  logic [WIDTH-1:0] dividend,
   input  logic [WIDTH-1:0] divisor,
   output logic             busy,
   output logic             done,
   output logic [WIDTH-1:0] quotient,
   output logic [WIDTH-1:0] remainder,
   output logic             overflow,
   output logic             div_by_zero
);

   localparam int CW = $clog2(WIDTH) + 1;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t           state_q, state_d;
   logic [WIDTH:0]   rem_q;
   logic [WIDTH-1:0] dq_q;
   logic [WIDTH-1:0] dvs_q;
   logic [CW-1:0]    cnt_q;
   logic             a_neg_q, b_neg_q, ovf_pend_q;
   logic [WIDTH-1:0] quotient_q, remainder_q;
   logic             overflow_q;

   logic             accept_s, dz_start_s;
   logic [WIDTH-1:0] a_mag_s, b_mag_s;
   logic             a_min_s, b_neg1_s;
   logic [WIDTH:0]   shifted_s, rem_step_s;
   logic [WIDTH+1:0] trial_s;
   logic             trial_neg_s, last_step_s;
   logic [WIDTH-1:0] dq_step_s, q_fix_s, r_fix_s;

   assign accept_s = (state_q == S_IDLE) && start;
   assign a_mag_s  = dividend[WIDTH-1] ? (~dividend + WIDTH'(1)) : dividend;
   assign b_mag_s  = divisor[WIDTH-1]  ? (~divisor + WIDTH'(1))  : divisor;
   assign a_min_s  = (dividend == {1'b1, {(WIDTH-1){1'b0}}});
   assign b_neg1_s = (divisor == {WIDTH{1'b1}});

`ifdef DIV_ZERO_DETECT_EN
   logic dbz_q;
   logic div_zero_s;
   assign div_zero_s  = (divisor == {WIDTH{1'b0}});
   assign dz_start_s  = accept_s && div_zero_s;
   assign div_by_zero = dbz_q;
`else
   assign dz_start_s  = 1'b0;
   assign div_by_zero = 1'b0;
`endif

   // One restoring step; the partial remainder never exceeds 2*|divisor| so WIDTH+1 bits suffice.
   assign shifted_s   = {rem_q[WIDTH-1:0], dq_q[WIDTH-1]};
   assign trial_s     = {1'b0, shifted_s} - {2'b00, dvs_q};
   assign trial_neg_s = trial_s[WIDTH+1];
   assign rem_step_s  = trial_neg_s ? shifted_s : trial_s[WIDTH:0];
   assign dq_step_s   = {dq_q[WIDTH-2:0], ~trial_neg_s};
   assign last_step_s = (cnt_q == CW'(WIDTH - 1));
   assign q_fix_s     = (a_neg_q ^ b_neg_q) ? (~dq_step_s + WIDTH'(1)) : dq_step_s;
   assign r_fix_s     = a_neg_q ? (~rem_step_s[WIDTH-1:0] + WIDTH'(1)) : rem_step_s[WIDTH-1:0];

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (dz_start_s) begin
               state_d = S_DONE;
            end else if (start) begin
               state_d = S_CALC;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_CALC: begin
            if (last_step_s) begin
               state_d = S_DONE;
            end else begin
               state_d = S_CALC;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // FSM outputs
   always_comb begin
      busy = 1'b0;
      done = 1'b0;
      case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            done = 1'b0;
         end
         S_CALC: begin
            busy = 1'b1;
            done = 1'b0;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
            done = 1'b0;
         end
      endcase
   end

   // Operand capture, iteration and result registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rem_q       <= {(WIDTH+1){1'b0}};
         dq_q        <= {WIDTH{1'b0}};
         dvs_q       <= {WIDTH{1'b0}};
         cnt_q       <= {CW{1'b0}};
         a_neg_q     <= 1'b0;
         b_neg_q     <= 1'b0;
         ovf_pend_q  <= 1'b0;
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
         overflow_q  <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q       <= 1'b0;
`endif
      end else if (accept_s) begin
         rem_q      <= {(WIDTH+1){1'b0}};
         dq_q       <= a_mag_s;
         dvs_q      <= b_mag_s;
         cnt_q      <= {CW{1'b0}};
         a_neg_q    <= dividend[WIDTH-1];
         b_neg_q    <= divisor[WIDTH-1];
         ovf_pend_q <= a_min_s && b_neg1_s;
         overflow_q <= 1'b0;
`ifdef DIV_ZERO_DETECT_EN
         dbz_q      <= div_zero_s;
         if (div_zero_s) begin
            quotient_q  <= {WIDTH{1'b1}};
            remainder_q <= dividend;
         end else begin
            quotient_q  <= {WIDTH{1'b0}};
            remainder_q <= {WIDTH{1'b0}};
         end
`else
         quotient_q  <= {WIDTH{1'b0}};
         remainder_q <= {WIDTH{1'b0}};
`endif
      end else if (state_q == S_CALC) begin
         rem_q <= rem_step_s;
         dq_q  <= dq_step_s;
         cnt_q <= cnt_q + CW'(1);
         if (last_step_s) begin
            quotient_q  <= q_fix_s;
            remainder_q <= r_fix_s;
            overflow_q  <= ovf_pend_q;
         end
      end
   end

   assign quotient  = quotient_q;
   assign remainder = remainder_q;
   assign overflow  = overflow_q;

endmodule
